// File: rtl/serial_rca_sequencer_pkg.sv
// Shared types and default sizing for the serial ripple-carry sequencer.
package serial_rca_pkg;

    // Default operand width, slice width and number of slice passes per add.
    localparam int DATA_W  = 32;
    localparam int SLICE_W = 4;
    localparam int N       = DATA_W / SLICE_W;

    // Control states of the sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_rca_pkg

// File: rtl/serial_rca_sequencer_if.sv
// Operand/result handshake bundle between producer, sequencer and consumer.
interface serial_rca_sequencer_if #(
    parameter int WIDTH = serial_rca_pkg::DATA_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C_Out;
    logic             busy;

    // Producer/consumer view (drives operands and result acceptance).
    modport master (
        output in_valid, A, B, C0, out_ready,
        input  in_ready, out_valid, S, C_Out, busy
    );

    // Sequencer view.
    modport slave (
        input  in_valid, A, B, C0, out_ready,
        output in_ready, out_valid, S, C_Out, busy
    );
endinterface : serial_rca_sequencer_if

// File: rtl/serial_rca_sequencer_slice.sv
// Four-bit ripple-carry adder slice: S = A + B + C0, carry out on C4.
module FourBitRCA_Standard (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] S,
    output logic       C4
);
    logic carry;

    // Ripple the carry through four full adders, LSB first.
    // NOTE: blocking '=' in combinational logic lets 'carry' chain within one evaluation; every output is assigned before any branch so no latch is inferred.
    always_comb begin
        carry = C0;
        S     = '0;
        for (int i = 0; i < 4; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        C4 = carry;
    end
endmodule : FourBitRCA_Standard

// File: rtl/serial_rca_sequencer.sv
// Serial adder: one 4-bit ripple-carry slice reused over WIDTH/SLICE cycles,
// with the carry registered between passes and valid/ready on both sides.
module serial_rca_sequencer
    import serial_rca_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SLICE = SLICE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_rca_sequencer_if.slave bus
);
    localparam int N_SL = WIDTH / SLICE;
    localparam int KW   = (N_SL > 1) ? $clog2(N_SL) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_SL - 1);

    // Operands and sum stored as arrays of slices so k selects one nibble directly.
    state_e                       state_q, state_d;
    logic [KW-1:0]                k_q, k_d;
    logic [N_SL-1:0][SLICE-1:0]   a_q, a_d;
    logic [N_SL-1:0][SLICE-1:0]   b_q, b_d;
    logic [N_SL-1:0][SLICE-1:0]   s_q, s_d;
    logic                         carry_q, carry_d;
    logic                         cout_q, cout_d;

    logic [SLICE-1:0]             slice_sum;
    logic                         slice_cout;

    // The single shared slice: current operand nibbles plus the registered carry.
    FourBitRCA_Standard u_slice (
        .A  (a_q[k_q]),
        .B  (b_q[k_q]),
        .C0 (carry_q),
        .S  (slice_sum),
        .C4 (slice_cout)
    );

    // State, counter, operand and result registers.
    // NOTE: sequential state uses '<=' so every register samples pre-edge values; the operand and sum arrays are plain flops here, so they reset with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state logic: accept in IDLE, one slice per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.C0;
                    k_d     = '0;
                    s_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[k_q] = slice_sum;
                carry_d  = slice_cout;
                if (k_q == K_LAST) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q == RUN) || (state_q == DONE);
        bus.S         = s_q;
        bus.C_Out     = cout_q;
    end
endmodule : serial_rca_sequencer
